// File: rtl/regfile_mp.sv
// Multi-port register file with optional write-to-read bypass, hardwired-zero R0
// and a per-entry pending-write scoreboard for load-use hazard detection.
module regfile_mp #(
    parameter int unsigned AW      = 5,
    parameter int unsigned ENTRY   = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned NRP     = 3,
    parameter int unsigned NWP     = 2,
    parameter int unsigned ZERO_R0 = 1,
    parameter int unsigned BYPASS  = 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [NWP-1:0]    WEN,
    input  logic [NWP*AW-1:0] WA,
    input  logic [NWP*DW-1:0] DI,
    input  logic [NRP*AW-1:0] RA,
    output logic [NRP*DW-1:0] DOUT,
    output logic [NRP-1:0]    RBUSY,
    input  logic              SB_SET,
    input  logic [AW-1:0]     SB_SA,
    input  logic              SB_FLUSH
);

    logic [DW-1:0]    mem_q [ENTRY];
    logic [DW-1:0]    mem_d [ENTRY];
    logic [ENTRY-1:0] pend_q;
    logic [ENTRY-1:0] pend_d;

    // An address names a real, writable register (in range and not the hardwired R0).
    function automatic logic addr_ok(input logic [AW-1:0] a);
        return (32'(a) < ENTRY) && !((ZERO_R0 != 0) && (a == '0));
    endfunction

    // Ascending port order makes the highest-indexed writer win on a collision.
    always_comb begin : write_next
        mem_d = mem_q;
        for (int unsigned k = 0; k < NWP; k++) begin
            if (WEN[k] && addr_ok(WA[k*AW +: AW])) begin
                mem_d[WA[k*AW +: AW]] = DI[k*DW +: DW];
            end
        end
    end

    // Clears are applied before the set so a freshly issued producer stays pending.
    always_comb begin : pend_next
        pend_d = pend_q;
        if (SB_FLUSH) begin
            pend_d = '0;
        end else begin
            for (int unsigned k = 0; k < NWP; k++) begin
                if (WEN[k] && addr_ok(WA[k*AW +: AW])) begin
                    pend_d[WA[k*AW +: AW]] = 1'b0;
                end
            end
            if (SB_SET && addr_ok(SB_SA)) begin
                pend_d[SB_SA] = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            mem_q  <= '{default: '0};
            pend_q <= '0;
        end else begin
            mem_q  <= mem_d;
            pend_q <= pend_d;
        end
    end

    // Forwarded data also hides the pending bit: the consumer gets the value this cycle.
    always_comb begin : read_ports
        DOUT  = '0;
        RBUSY = '0;
        for (int unsigned i = 0; i < NRP; i++) begin
            if (addr_ok(RA[i*AW +: AW])) begin
                DOUT[i*DW +: DW] = mem_q[RA[i*AW +: AW]];
                RBUSY[i]         = pend_q[RA[i*AW +: AW]];
                if (BYPASS != 0) begin
                    for (int unsigned k = 0; k < NWP; k++) begin
                        if (WEN[k] && (WA[k*AW +: AW] == RA[i*AW +: AW])) begin
                            DOUT[i*DW +: DW] = DI[k*DW +: DW];
                            RBUSY[i]         = 1'b0;
                        end
                    end
                end
            end
        end
    end

endmodule
